// File: rtl/serial_adder.sv
// Purpose : bit-serial adder, LSB first, one full-adder slice plus a registered carry.
// Latency : result valid WIDTH edges after the accepting edge; one operation in flight.
// Backpressure: IN_READY only in IDLE; result held in DONE until OUT_READY.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   IN_VALID/IN_READY   operand handshake for A, B, C_I
//   OUT_VALID/OUT_READY result handshake for S, C_O (and OVF)
//   S, C_O              registered sum modulo 2^WIDTH and carry-out of the MSB
//   OVF                 registered signed overflow, only when SERIAL_ADDER_OVF_EN is defined
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_I,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] S,
   output logic             C_O
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             OVF
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             sum_bit;
   logic             carry_out;
   logic             last_bit;

   // One-bit full-adder slice on the current LSBs and the carry flop.
   assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
   assign carry_out = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
   assign last_bit  = (cnt == LAST_BIT);

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs
   always_comb begin
      state_nxt = state;
      IN_READY  = 1'b0;
      OUT_VALID = 1'b0;
      case (state)
         IDLE: begin
            IN_READY = 1'b1;
            if (IN_VALID) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            OUT_VALID = 1'b1;
            if (OUT_READY) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: operand shifters, carry, bit counter and result registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         S      <= '0;
         C_O    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         OVF    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (IN_VALID) begin
                  a_sh  <= A;
                  b_sh  <= B;
                  carry <= C_I;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= carry_out;
               // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
               res_sh <= {sum_bit, res_sh[WIDTH-1:1]};
               if (last_bit) begin
                  S   <= {sum_bit, res_sh[WIDTH-1:1]};
                  C_O <= carry_out;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry flop holds the carry into the MSB on this cycle
                  OVF <= carry ^ carry_out;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   localparam int WIDTH = 8;

   logic             CLK = 1'b0;
   logic             RST_N;
   logic             IN_VALID;
   logic             IN_READY;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             C_I;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [WIDTH-1:0] S;
   logic             C_O;
`ifdef SERIAL_ADDER_OVF_EN
   logic             OVF;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .IN_VALID (IN_VALID),
      .IN_READY (IN_READY),
      .A        (A),
      .B        (B),
      .C_I      (C_I),
      .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY),
      .S        (S),
      .C_O      (C_O)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .OVF      (OVF)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: integer arithmetic on the operands.
   task automatic ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                          output logic [WIDTH-1:0] s, output logic co, output logic ov);
      longint us;
      longint ss;
      longint sa;
      longint sb;
      us = longint'(a) + longint'(b) + longint'(ci);
      s  = WIDTH'(us % (longint'(1) << WIDTH));
      co = (us >= (longint'(1) << WIDTH));
      sa = (a[WIDTH-1]) ? longint'(a) - (longint'(1) << WIDTH) : longint'(a);
      sb = (b[WIDTH-1]) ? longint'(b) - (longint'(1) << WIDTH) : longint'(b);
      ss = sa + sb + longint'(ci);
      ov = (ss > (longint'(1) << (WIDTH - 1)) - 1) || (ss < -(longint'(1) << (WIDTH - 1)));
   endtask

   // Full operation: accept, measure latency, check result, hold in DONE, release.
   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                        input int hold, input bit noisy);
      int n;
      logic [WIDTH-1:0] es;
      logic ec;
      logic ev;
      ref_add(a, b, ci, es, ec, ev);
      n = 0;
      while (!IN_READY && n < 20) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("in_ready_idle", IN_READY, 1);
      A = a; B = b; C_I = ci; IN_VALID = 1'b1;
      @(posedge CLK); #1;                       // accepting edge
      IN_VALID = 1'b0;
      A = WIDTH'($urandom); B = WIDTH'($urandom); C_I = 1'($urandom);
      n = 0;
      while (!OUT_VALID && n < WIDTH + 4) begin
         chk("in_ready_run", IN_READY, 0);
         if (noisy) begin
            OUT_READY = 1'($urandom);
            IN_VALID  = 1'($urandom);
            A = WIDTH'($urandom); B = WIDTH'($urandom);
         end
         @(posedge CLK); #1;
         n++;
      end
      OUT_READY = 1'b0;
      chk("latency", n, WIDTH);
      chk("out_valid", OUT_VALID, 1);
      chk("sum", S, es);
      chk("carry_out", C_O, ec);
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf", OVF, ev);
`endif
      for (int h = 0; h < hold; h++) begin
         IN_VALID = 1'($urandom);
         A = WIDTH'($urandom); B = WIDTH'($urandom); C_I = 1'($urandom);
         @(posedge CLK); #1;
         chk("hold_valid", OUT_VALID, 1);
         chk("hold_in_ready", IN_READY, 0);
         chk("hold_sum", S, es);
         chk("hold_carry", C_O, ec);
      end
      IN_VALID = 1'b0;
      OUT_READY = 1'b1;
      @(posedge CLK); #1;
      OUT_READY = 1'b0;
      chk("exit_valid", OUT_VALID, 0);
      chk("exit_in_ready", IN_READY, 1);
      chk("exit_sum_held", S, es);
      chk("exit_carry_held", C_O, ec);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
      A = '0; B = '0; C_I = 1'b0;
      #12;
      chk("rst_in_ready", IN_READY, 1);
      chk("rst_out_valid", OUT_VALID, 0);
      chk("rst_sum", S, 0);
      chk("rst_carry", C_O, 0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("rst_ovf", OVF, 0);
`endif
      @(negedge CLK); RST_N = 1'b1;
      @(posedge CLK); #1;

      // Directed corner cases
      do_op(8'h0F, 8'h01, 1'b0, 0, 0);
      do_op(8'hFF, 8'h01, 1'b0, 1, 0);
      do_op(8'h7F, 8'h01, 1'b0, 0, 0);
      do_op(8'hFF, 8'hFF, 1'b1, 5, 0);
      do_op(8'h80, 8'h80, 1'b0, 0, 0);

      // Reset after three RUN cycles aborts the operation
      chk("pre_abort_ready", IN_READY, 1);
      A = 8'hAA; B = 8'h55; C_I = 1'b1; IN_VALID = 1'b1;
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RST_N = 1'b0;
      #1;
      chk("abort_out_valid", OUT_VALID, 0);
      chk("abort_sum", S, 0);
      chk("abort_carry", C_O, 0);
      chk("abort_in_ready", IN_READY, 1);
      @(negedge CLK); RST_N = 1'b1;
      #1;
      chk("release_in_ready", IN_READY, 1);
      repeat (WIDTH + 2) begin
         @(posedge CLK); #1;
         chk("abort_no_result", OUT_VALID, 0);
      end
      do_op(8'h01, 8'h02, 1'b0, 0, 0);

      // Randomized operations with random hold and noisy ignored inputs
      for (int i = 0; i < 40; i++) begin
         do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
